// File: rtl/rx_ber_pkg.sv
// Shared definitions for the RX bit-error-rate checker: FSM state encoding,
// default parameter values and a saturating-increment helper.
package rx_ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] DEF_MAX_RX_COUNT = 32'h4C4B400;
    localparam int unsigned DEF_LOCK_LEN     = 16;
    localparam int unsigned DEF_UNLOCK_ERR   = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rx_bit_sync.sv
// Two-flop synchronizer for the serial input coming from the transmitter board.
module rx_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/rx_ber_checker.sv
// Alternating-pattern BER checker: hunts for lock, counts checked bits and errors.
// Define RX_SYNC_EN to place a 2-flop synchronizer in front of the checker.
//
// state  | meaning
// IDLE   | disabled, counters held
// HUNT   | looking for LOCK_LEN consecutive toggling bits
// LOCKED | comparing against free-running expected bit, counting
// DONE   | MAX_RX_COUNT bits checked, everything frozen until rst/clr
module rx_ber_checker
    import rx_ber_pkg::*;
#(
    parameter logic [31:0] MAX_RX_COUNT = DEF_MAX_RX_COUNT,
    parameter int unsigned LOCK_LEN     = DEF_LOCK_LEN,
    parameter int unsigned UNLOCK_ERR   = DEF_UNLOCK_ERR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_bit_data,
    input  logic        rx_en,
    input  logic        clr,
    output logic [31:0] rx_count,
    output logic [31:0] err_count,
    output logic        locked,
    output logic        max_rx_flag,
    output logic        err_flag
);

    localparam logic [31:0] LOCK_LAST  = 32'(LOCK_LEN - 1);
    localparam logic [31:0] UNLOCK_LIM = 32'(UNLOCK_ERR);

    logic rx_s;

`ifdef RX_SYNC_EN
    rx_bit_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx_bit_data),
        .dout (rx_s)
    );
`else
    assign rx_s = rx_bit_data;
`endif

    state_t      state, state_nxt;
    logic        prev_s;
    logic        expect_bit, expect_nxt;
    logic [31:0] hunt_cnt, hunt_nxt;
    logic [31:0] consec_err, consec_nxt;
    logic [31:0] rx_count_nxt, err_count_nxt;
    logic        max_nxt, err_flag_nxt, locked_nxt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state       <= ST_IDLE;
            prev_s      <= rst ? 1'b0 : rx_s;
            expect_bit  <= 1'b0;
            hunt_cnt    <= '0;
            consec_err  <= '0;
            rx_count    <= '0;
            err_count   <= '0;
            locked      <= 1'b0;
            max_rx_flag <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_s      <= rx_s;
            expect_bit  <= expect_nxt;
            hunt_cnt    <= hunt_nxt;
            consec_err  <= consec_nxt;
            rx_count    <= rx_count_nxt;
            err_count   <= err_count_nxt;
            locked      <= locked_nxt;
            max_rx_flag <= max_nxt;
            err_flag    <= err_flag_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        expect_nxt    = expect_bit;
        hunt_nxt      = hunt_cnt;
        consec_nxt    = consec_err;
        rx_count_nxt  = rx_count;
        err_count_nxt = err_count;
        max_nxt       = max_rx_flag;
        err_flag_nxt  = err_flag;

        case (state)
            ST_IDLE: begin
                hunt_nxt = '0;
                if (rx_en) state_nxt = ST_HUNT;
            end
            ST_HUNT: begin
                if (!rx_en) begin
                    state_nxt = ST_IDLE;
                    hunt_nxt  = '0;
                end else if (rx_s != prev_s) begin
                    if (hunt_cnt >= LOCK_LAST) begin
                        state_nxt  = ST_LOCKED;
                        expect_nxt = ~rx_s;
                        consec_nxt = '0;
                        hunt_nxt   = '0;
                    end else begin
                        hunt_nxt = hunt_cnt + 32'd1;
                    end
                end else begin
                    hunt_nxt = '0;
                end
            end
            ST_LOCKED: begin
                if (!rx_en) begin
                    state_nxt = ST_IDLE;
                end else begin
                    // Expected phase free-runs; a slipped stream is caught by UNLOCK_ERR.
                    expect_nxt = ~expect_bit;
                    if (rx_count < MAX_RX_COUNT) rx_count_nxt = rx_count + 32'd1;
                    if (rx_s != expect_bit) begin
                        err_count_nxt = sat_inc(err_count);
                        err_flag_nxt  = 1'b1;
                        consec_nxt    = consec_err + 32'd1;
                    end else begin
                        consec_nxt = '0;
                    end
                    if (rx_count_nxt >= MAX_RX_COUNT) begin
                        state_nxt = ST_DONE;
                        max_nxt   = 1'b1;
                    end else if (consec_nxt >= UNLOCK_LIM) begin
                        state_nxt  = ST_HUNT;
                        hunt_nxt   = '0;
                        consec_nxt = '0;
                    end
                end
            end
            ST_DONE: begin
                max_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        locked_nxt = (state_nxt == ST_LOCKED);
    end

endmodule

// File: tb/tb_rx_ber_checker.sv
// Scoreboard bench for rx_ber_checker: stimulus queues expected outputs stamped
// with a cycle number, a negedge monitor pops and compares them.
module tb_rx_ber_checker;

`ifdef RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic        rx_bit_data;
    logic        rx_en;
    logic        clr;
    logic [31:0] rx_count;
    logic [31:0] err_count;
    logic        locked;
    logic        max_rx_flag;
    logic        err_flag;

    rx_ber_checker #(
        .MAX_RX_COUNT (32'd100),
        .LOCK_LEN     (16),
        .UNLOCK_ERR   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_bit_data (rx_bit_data),
        .rx_en       (rx_en),
        .clr         (clr),
        .rx_count    (rx_count),
        .err_count   (err_count),
        .locked      (locked),
        .max_rx_flag (max_rx_flag),
        .err_flag    (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          target;
        string       name;
        logic [31:0] rxc;
        logic [31:0] errc;
        logic        lk;
        logic        mx;
        logic        ef;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic ph;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s actual=%0d required=%0d (cycle %0d)", nm, fld, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].target <= cyc) begin
            cur = sb.pop_front();
            if (cur.target != cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s missed check: target=%0d now=%0d", cur.name, cur.target, cyc);
            end else begin
                chk(cur.name, "rx_count",    rx_count,             cur.rxc);
                chk(cur.name, "err_count",   err_count,            cur.errc);
                chk(cur.name, "locked",      {31'd0, locked},      {31'd0, cur.lk});
                chk(cur.name, "max_rx_flag", {31'd0, max_rx_flag}, {31'd0, cur.mx});
                chk(cur.name, "err_flag",    {31'd0, err_flag},    {31'd0, cur.ef});
            end
        end
    end

    task automatic expect_now(input string nm, input int rxc, input int errc,
                              input logic lk, input logic mx, input logic ef);
        exp_t e;
        e.target = cyc;
        e.name   = nm;
        e.rxc    = 32'(rxc);
        e.errc   = 32'(errc);
        e.lk     = lk;
        e.mx     = mx;
        e.ef     = ef;
        sb.push_back(e);
    endtask

    task automatic step(input logic b);
        rx_bit_data = b;
        @(posedge clk);
        #1;
    endtask

    // Alternating stream; flip inverts one bit without disturbing the phase.
    task automatic alt(input logic flip);
        step(ph ^ flip);
        ph = ~ph;
    endtask

    task automatic start(input string nm);
        rst   = 1'b1;
        clr   = 1'b0;
        rx_en = 1'b1;
        ph    = 1'b0;
        step(1'b0);
        expect_now(nm, 0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; rx_en = 1'b0; rx_bit_data = 1'b0; ph = 1'b0;

        // Clean stream to MAX_RX_COUNT, then a bad bit that DONE must ignore.
        start("reset_a");
        for (int e = 0; e < 120; e++) begin
            alt(e == 117);
            if (e == 15 + LAT)  expect_now("a_prelock", 0,   0, 1'b0, 1'b0, 1'b0);
            if (e == 16 + LAT)  expect_now("a_lock",    0,   0, 1'b1, 1'b0, 1'b0);
            if (e == 66 + LAT)  expect_now("a_mid",     50,  0, 1'b1, 1'b0, 1'b0);
            if (e == 115 + LAT) expect_now("a_premax",  99,  0, 1'b1, 1'b0, 1'b0);
            if (e == 116 + LAT) expect_now("a_max",     100, 0, 1'b0, 1'b1, 1'b0);
            if (e == 119)       expect_now("a_done",    100, 0, 1'b0, 1'b1, 1'b0);
        end

        // Reset out of DONE, relock, count restarts from zero.
        start("reset_done");
        for (int e = 0; e < 21 + LAT; e++) begin
            alt(1'b0);
            if (e == 16 + LAT) expect_now("b_lock", 0, 0, 1'b1, 1'b0, 1'b0);
            if (e == 20 + LAT) expect_now("b_cnt",  4, 0, 1'b1, 1'b0, 1'b0);
        end

        // Three isolated flips while locked, then rx_en dropped.
        start("reset_c");
        for (int e = 0; e <= 83; e++) begin
            rx_en = (e < 81);
            alt(e == 30 || e == 50 || e == 70);
            if (e == 29 + LAT) expect_now("c_preflip", 13,       0, 1'b1, 1'b0, 1'b0);
            if (e == 30 + LAT) expect_now("c_flip1",   14,       1, 1'b1, 1'b0, 1'b1);
            if (e == 80)       expect_now("c_flips",   64 - LAT, 3, 1'b1, 1'b0, 1'b1);
            if (e == 83)       expect_now("c_en_low",  64 - LAT, 3, 1'b0, 1'b0, 1'b1);
        end

        // One-bit slip: 8 consecutive errors drop lock, then relock.
        start("reset_d");
        for (int e = 0; e < 66 + LAT; e++) begin
            if (e == 40) step(~ph);
            else alt(1'b0);
            if (e == 46 + LAT) expect_now("d_err7",   30, 7, 1'b1, 1'b0, 1'b1);
            if (e == 47 + LAT) expect_now("d_unlock", 31, 8, 1'b0, 1'b0, 1'b1);
            if (e == 62 + LAT) expect_now("d_hunt",   31, 8, 1'b0, 1'b0, 1'b1);
            if (e == 63 + LAT) expect_now("d_relock", 31, 8, 1'b1, 1'b0, 1'b1);
            if (e == 64 + LAT) expect_now("d_count",  32, 8, 1'b1, 1'b0, 1'b1);
        end

        // clr at rx_count=50 wipes counters and flags, then relock from IDLE.
        start("reset_e");
        for (int e = 0; e <= 87 + LAT; e++) begin
            clr = (e == 67 + LAT);
            alt(e == 40);
            if (e == 40 + LAT) expect_now("e_flip",    24, 1, 1'b1, 1'b0, 1'b1);
            if (e == 66 + LAT) expect_now("e_preclr",  50, 1, 1'b1, 1'b0, 1'b1);
            if (e == 67 + LAT) expect_now("e_clr",     0,  0, 1'b0, 1'b0, 1'b0);
            if (e == 83 + LAT) expect_now("e_prelock", 0,  0, 1'b0, 1'b0, 1'b0);
            if (e == 84 + LAT) expect_now("e_relock",  0,  0, 1'b1, 1'b0, 1'b0);
            if (e == 87 + LAT) expect_now("e_count",   3,  0, 1'b1, 1'b0, 1'b0);
        end
        clr = 1'b0;

        // rst wins over a simultaneous clr.
        rst = 1'b1; clr = 1'b1;
        step(1'b0);
        expect_now("rst_clr", 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; clr = 1'b0; rx_en = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b0);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_ber_checker.md
RX_BER_CHECKER -- requirements
Module: rx_ber_checker

Interface
REQ-001 Parameter MAX_RX_COUNT, default 32'h4C4B400, number of locked bits to check before done (80 million).
REQ-002 Parameter LOCK_LEN, default 16, consecutive pattern-correct bits required to acquire lock.
REQ-003 Parameter UNLOCK_ERR, default 8, consecutive mismatches that drop lock.
REQ-004 clk  input  1  bit clock, 9.437 MHz, single clock domain; reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rx_bit_data  input  1  serial alternating-bit stream from the transmitter board, one bit per clk.
REQ-007 rx_en  input  1  check enable; low means idle with counters held.
REQ-008 clr  input  1  single-cycle clear of counters and state.
REQ-009 rx_count  output  32  locked bits checked.
REQ-010 err_count  output  32  mismatched bits while locked, saturating.
REQ-011 locked  output  1  high while in LOCKED state.
REQ-012 max_rx_flag  output  1  high once rx_count reaches MAX_RX_COUNT.
REQ-013 err_flag  output  1  sticky, high once err_count is nonzero.

Function
REQ-014 rx_s = rx_bit_data after the input stage (REQ-030/031); all checking uses rx_s; all outputs registered.
REQ-015 States: IDLE, HUNT, LOCKED, DONE; encoding from the shared package.
REQ-016 IDLE: rx_en=1 -> HUNT next edge; counters hold.
REQ-017 HUNT: match = (rx_s != previous rx_s); hunt_cnt increments on match, clears to 0 on mismatch; hunt_cnt reaching LOCK_LEN -> LOCKED, with expected bit for the next cycle = ~rx_s.
REQ-018 LOCKED: each cycle rx_count+1; mismatch (rx_s != expected) -> err_count+1, consec_err+1; match -> consec_err=0; expected toggles every cycle without resync.
REQ-019 LOCKED: consec_err reaching UNLOCK_ERR -> HUNT, locked=0, hunt_cnt=0; rx_count/err_count retained.
REQ-020 LOCKED: rx_count reaching MAX_RX_COUNT -> DONE; max_rx_flag=1 on the same edge that rx_count becomes MAX_RX_COUNT; if that last bit is a mismatch it is counted.
REQ-021 DONE: all counters frozen, max_rx_flag held until rst or clr; rx_bit_data ignored.
REQ-022 rx_en low in any state except DONE -> IDLE next edge; counters, err_flag hold; locked=0.
REQ-023 clr (rst absent) -> rx_count=0, err_count=0, err_flag=0, max_rx_flag=0, hunt_cnt=0, consec_err=0, state IDLE; clr has priority over all other events.
REQ-024 err_count saturates at 32'hFFFFFFFF; rx_count never exceeds MAX_RX_COUNT.
REQ-025 err_flag set on the same edge err_count first becomes nonzero.

Reset
REQ-026 rst sampled on rising clk only; priority over clr and rx_en.
REQ-027 Reset values: rx_count=0, err_count=0, locked=0, max_rx_flag=0, err_flag=0, state IDLE, hunt_cnt=0, consec_err=0, synchronizer flops=0.
REQ-028 rst mid-LOCKED or mid-DONE discards all progress; checking restarts through HUNT once rx_en is high.

Configuration
REQ-029 Macro RX_SYNC_EN selects the input stage.
REQ-030 RX_SYNC_EN defined: rx_s is rx_bit_data through a 2-flop synchronizer (2-cycle latency).
REQ-031 RX_SYNC_EN undefined: rx_s = rx_bit_data directly (0-cycle latency); counter and state behaviour otherwise identical.

Structure
REQ-032 Shared package rx_ber_pkg holds the state encoding and the default values of MAX_RX_COUNT, LOCK_LEN and UNLOCK_ERR.
REQ-033 Sub-module rx_bit_sync implements the 2-flop synchronizer, instantiated only when RX_SYNC_EN is defined.

Verification
REQ-034 rx_en=1, clean alternating stream, LOCK_LEN=16 -> locked rises after 16 matches; with MAX_RX_COUNT=100, max_rx_flag=1, rx_count=100, err_count=0, err_flag=0.
REQ-035 Locked stream with 3 single-bit flips spaced 20 bits apart -> err_count=3, err_flag=1, locked stays 1.
REQ-036 Locked stream with a one-bit slip (repeat one bit) -> 8 consecutive mismatches, locked=0, HUNT, relock after 16 matches; err_count=8 retained.
REQ-037 clr asserted in LOCKED at rx_count=50 -> next cycle all counters 0, state IDLE, then HUNT since rx_en=1.
REQ-038 rst asserted in DONE -> all outputs at reset values on the next edge; rx_count restarts from 0 after relock.
REQ-039 Run REQ-034 with and without RX_SYNC_EN -> identical final counts; locked rises 2 cycles later with the macro defined.
